des_round_sequencer: RTL

//   Control sequencer for the iterative DES round datapath: expansion, S-boxes and P permutation.

---
 rtl/des_round_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/des_round_sequencer.sv
// Control sequencer for the iterative DES round datapath.
// Accepts one block job per handshake, steps 16 rounds of ROUND_LAT cycles each,
// drives key-schedule rotate amount/direction, and hands the result to the consumer.
module des_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned ROUND_LAT  = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             decrypt,
  input  logic             abort,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [3:0]       round_idx,
  output logic [1:0]       key_shift,
  output logic             key_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_done
);

  localparam int unsigned RIDX_W = 4;
  localparam int unsigned SUB_W  = 3;
  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS - 1);
  localparam logic [SUB_W-1:0]  LAST_SUB   = SUB_W'(ROUND_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RIDX_W-1:0]   round_idx_q, round_idx_d;
  logic [SUB_W-1:0]    sub_q, sub_d;
  logic                key_dir_q, key_dir_d;
  logic [CNT_W-1:0]    blocks_done_q, blocks_done_d;

  // Per-round left-rotate amount of the DES key schedule (rounds 0,1,8,15 rotate by one).
  function automatic logic [1:0] shift_tbl(input logic [RIDX_W-1:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd15: shift_tbl = 2'd1;
      default:                 shift_tbl = 2'd2;
    endcase
  endfunction

  // Next-state, counters and datapath strobes.
  always_comb begin
    state_d       = state_q;
    round_idx_d   = round_idx_q;
    sub_d         = sub_q;
    key_dir_d     = key_dir_q;
    blocks_done_d = blocks_done_q;
    in_ready      = 1'b0;
    dp_load       = 1'b0;
    dp_round_en   = 1'b0;
    key_shift     = 2'd0;

    case (state_q)
      S_IDLE: begin
        in_ready = ~abort & ~rst;
        if (in_valid && in_ready) begin
          dp_load     = 1'b1;
          key_dir_d   = decrypt;
          round_idx_d = '0;
          sub_d       = '0;
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        // Decrypt undoes the rotations in reverse order, so no rotate before round 0.
        if (key_dir_q) begin
          key_shift = (round_idx_q == '0) ? 2'd0
                    : shift_tbl(RIDX_W'(5'd16 - {1'b0, round_idx_q}));
        end else begin
          key_shift = shift_tbl(round_idx_q);
        end
        if (sub_q == LAST_SUB) begin
          dp_round_en = 1'b1;
          sub_d       = '0;
          if (round_idx_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_idx_d = round_idx_q + RIDX_W'(1);
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          blocks_done_d = blocks_done_q + CNT_W'(1);
          round_idx_d   = '0;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: cancel the job, suppress strobes, do not count.
    if (abort) begin
      state_d       = S_IDLE;
      round_idx_d   = '0;
      sub_d         = '0;
      blocks_done_d = blocks_done_q;
      dp_load       = 1'b0;
      dp_round_en   = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      round_idx_q   <= '0;
      sub_q         <= '0;
      key_dir_q     <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q       <= state_d;
      round_idx_q   <= round_idx_d;
      sub_q         <= sub_d;
      key_dir_q     <= key_dir_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  assign round_idx   = round_idx_q;
  assign key_dir     = key_dir_q;
  assign blocks_done = blocks_done_q;
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

endmodule
